// File: rtl/gate_operand_fetch.sv
// gate_operand_fetch: operand-fetch stage between descriptor queue and garbling core.
// Ports: gd_* descriptor in (valid/ready), rd_* label RAM read ports, go_* operands
//        out (valid/ready), busy/stall_cnt/dep_timeout status; rst async active-low,
//        clr synchronous clear.
module gate_operand_fetch #(
    parameter int S  = 20,
    parameter int K  = 128,
    parameter int TW = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         gd_valid,
    output logic         gd_ready,
    input  logic [1:0]   gd_type,
    input  logic [S-1:0] gd_in_a,
    input  logic [S-1:0] gd_in_b,
    input  logic [S-1:0] gd_out,
    output logic [S-1:0] rd_addr_0,
    output logic [S-1:0] rd_addr_1,
    input  logic         rd_data_ready_0,
    input  logic         rd_data_ready_1,
    input  logic [K-1:0] rd_data_0,
    input  logic [K-1:0] rd_data_1,
    output logic         go_valid,
    input  logic         go_ready,
    output logic [1:0]   go_type,
    output logic [K-1:0] go_label_a,
    output logic [K-1:0] go_label_b,
    output logic [S-1:0] go_out,
    output logic         busy,
    output logic [31:0]  stall_cnt,
    output logic         dep_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_e;

    localparam logic [1:0]    T_INV     = 2'd2;
    localparam logic [TW-1:0] WAIT_MAX  = '1;
    localparam logic [TW-1:0] WAIT_TRIP = WAIT_MAX - {{(TW-1){1'b0}}, 1'b1};

    state_e         state_q, state_d;
    logic [1:0]     type_q, type_d;
    logic [S-1:0]   in_a_q, in_a_d;
    logic [S-1:0]   in_b_q, in_b_d;
    logic [S-1:0]   out_q, out_d;
    logic [1:0]     go_type_q, go_type_d;
    logic [K-1:0]   go_label_a_q, go_label_a_d;
    logic [K-1:0]   go_label_b_q, go_label_b_d;
    logic [S-1:0]   go_out_q, go_out_d;
    logic [31:0]    stall_cnt_q, stall_cnt_d;
    logic [TW-1:0]  wait_cnt_q, wait_cnt_d;
    logic           dep_timeout_q, dep_timeout_d;

    logic accept;
    logic need;

    assign gd_ready = (state_q == IDLE) | ((state_q == ISSUE) & go_ready);
    assign accept   = gd_valid & gd_ready;
    // INV only consumes operand A, so B's written flag is irrelevant.
    assign need     = rd_data_ready_0 & (rd_data_ready_1 | (type_q == T_INV));

    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        in_a_d        = in_a_q;
        in_b_d        = in_b_q;
        out_d         = out_q;
        go_type_d     = go_type_q;
        go_label_a_d  = go_label_a_q;
        go_label_b_d  = go_label_b_q;
        go_out_d      = go_out_q;
        stall_cnt_d   = stall_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        dep_timeout_d = dep_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (gd_valid) state_d = FETCH;
            end
            FETCH: begin
                if (need) begin
                    go_label_a_d = rd_data_0;
                    go_label_b_d = (type_q == T_INV) ? '0 : rd_data_1;
                    go_type_d    = type_q;
                    go_out_d     = out_q;
                    state_d      = ISSUE;
                end else begin
                    if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
                    if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
                    // Flag the gate the moment its wait count lands on the maximum.
                    if (wait_cnt_q == WAIT_TRIP) dep_timeout_d = 1'b1;
                end
            end
            ISSUE: begin
                if (go_ready) state_d = gd_valid ? FETCH : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Descriptor latch is shared by the IDLE and ISSUE hand-offs.
        if (accept) begin
            type_d     = gd_type;
            in_a_d     = gd_in_a;
            in_b_d     = gd_in_b;
            out_d      = gd_out;
            wait_cnt_d = '0;
        end

        if (clr) begin
            state_d       = IDLE;
            type_d        = '0;
            in_a_d        = '0;
            in_b_d        = '0;
            out_d         = '0;
            go_type_d     = '0;
            go_label_a_d  = '0;
            go_label_b_d  = '0;
            go_out_d      = '0;
            stall_cnt_d   = '0;
            wait_cnt_d    = '0;
            dep_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            type_q        <= '0;
            in_a_q        <= '0;
            in_b_q        <= '0;
            out_q         <= '0;
            go_type_q     <= '0;
            go_label_a_q  <= '0;
            go_label_b_q  <= '0;
            go_out_q      <= '0;
            stall_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            dep_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            in_a_q        <= in_a_d;
            in_b_q        <= in_b_d;
            out_q         <= out_d;
            go_type_q     <= go_type_d;
            go_label_a_q  <= go_label_a_d;
            go_label_b_q  <= go_label_b_d;
            go_out_q      <= go_out_d;
            stall_cnt_q   <= stall_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            dep_timeout_q <= dep_timeout_d;
        end
    end

    assign rd_addr_0   = in_a_q;
    assign rd_addr_1   = in_b_q;
    assign go_valid    = (state_q == ISSUE);
    assign go_type     = go_type_q;
    assign go_label_a  = go_label_a_q;
    assign go_label_b  = go_label_b_q;
    assign go_out      = go_out_q;
    assign busy        = (state_q != IDLE);
    assign stall_cnt   = stall_cnt_q;
    assign dep_timeout = dep_timeout_q;

endmodule

// File: tb/tb_gate_operand_fetch.sv
// tb_gate_operand_fetch: self-checking bench for gate_operand_fetch with a
// behavioural label RAM (write-once labels, flag set on the write edge).
module tb_gate_operand_fetch;

    localparam int S    = 6;
    localparam int K    = 64;
    localparam int TW   = 4;
    localparam int N    = 1 << S;
    localparam int TMAX = (1 << TW) - 1;

    logic         clk = 0;
    logic         rst = 0;
    logic         clr = 0;
    logic         gd_valid = 0;
    logic         gd_ready;
    logic [1:0]   gd_type = 0;
    logic [S-1:0] gd_in_a = 0;
    logic [S-1:0] gd_in_b = 0;
    logic [S-1:0] gd_out = 0;
    logic [S-1:0] rd_addr_0, rd_addr_1;
    logic         rd_data_ready_0, rd_data_ready_1;
    logic [K-1:0] rd_data_0, rd_data_1;
    logic         go_valid;
    logic         go_ready = 0;
    logic [1:0]   go_type;
    logic [K-1:0] go_label_a, go_label_b;
    logic [S-1:0] go_out;
    logic         busy;
    logic [31:0]  stall_cnt;
    logic         dep_timeout;

    gate_operand_fetch #(.S(S), .K(K), .TW(TW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .gd_valid(gd_valid), .gd_ready(gd_ready), .gd_type(gd_type),
        .gd_in_a(gd_in_a), .gd_in_b(gd_in_b), .gd_out(gd_out),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
        .rd_data_ready_0(rd_data_ready_0), .rd_data_ready_1(rd_data_ready_1),
        .rd_data_0(rd_data_0), .rd_data_1(rd_data_1),
        .go_valid(go_valid), .go_ready(go_ready), .go_type(go_type),
        .go_label_a(go_label_a), .go_label_b(go_label_b), .go_out(go_out),
        .busy(busy), .stall_cnt(stall_cnt), .dep_timeout(dep_timeout)
    );

    always #5 clk = ~clk;

    // Label RAM model
    logic         flag [N];
    logic [K-1:0] mem  [N];
    logic         wr_en = 0;
    logic         ram_clr = 0;
    logic [S-1:0] wr_addr = 0;
    logic [K-1:0] wr_data = 0;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < N; i++) flag[i] <= 1'b0;
        end else if (wr_en) begin
            flag[wr_addr] <= 1'b1;
            mem[wr_addr]  <= wr_data;
        end
    end

    assign rd_data_ready_0 = flag[rd_addr_0];
    assign rd_data_ready_1 = flag[rd_addr_1];
    assign rd_data_0       = mem[rd_addr_0];
    assign rd_data_1       = mem[rd_addr_1];

    // Reference state
    bit           have [N];
    logic [K-1:0] lbl  [N];
    int           checks = 0;
    int           errors = 0;
    longint       exp_stall = 0;
    bit           exp_to = 0;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic flush_ram;
        ram_clr = 1;
        tick();
        ram_clr = 0;
        for (int i = 0; i < N; i++) have[i] = 0;
    endtask

    task automatic ram_write(input logic [S-1:0] a, input logic [K-1:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
        have[a] = 1; lbl[a] = d;
    endtask

    task automatic send(input logic [1:0] t, input logic [S-1:0] a,
                        input logic [S-1:0] b, input logic [S-1:0] o,
                        output bit ok);
        gd_type = t; gd_in_a = a; gd_in_b = b; gd_out = o;
        gd_valid = 1; ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (gd_ready) begin ok = 1; break; end
            tick();
        end
        tick();
        gd_valid = 0;
    endtask

    function automatic logic [K-1:0] rnd_lbl();
        return {$urandom(), $urandom()};
    endfunction

    task automatic test_reset;
        rst = 0;
        flush_ram();
        #1;
        checks++; if (go_valid !== 1'b0) begin errors++; $display("FAIL reset_go_valid got=%0b exp=0", go_valid); end
        checks++; if (gd_ready !== 1'b1) begin errors++; $display("FAIL reset_gd_ready got=%0b exp=1", gd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
        checks++; if (dep_timeout !== 1'b0) begin errors++; $display("FAIL reset_dep got=%0b exp=0", dep_timeout); end
        checks++; if (rd_addr_0 !== '0 || rd_addr_1 !== '0) begin errors++; $display("FAIL reset_rd_addr got=%0d/%0d exp=0/0", rd_addr_0, rd_addr_1); end
        checks++; if (go_label_a !== '0 || go_label_b !== '0 || go_out !== '0 || go_type !== '0) begin errors++; $display("FAIL reset_go_regs got=%0h/%0h/%0d/%0d exp=0", go_label_a, go_label_b, go_out, go_type); end
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_basic;
        logic [K-1:0] la, lb;
        bit ok;
        flush_ram();
        la = rnd_lbl(); lb = rnd_lbl();
        ram_write(5, la);
        ram_write(9, lb);
        go_ready = 1;
        send(2'd1, 6'd5, 6'd9, 6'd12, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_accept got=0 exp=1"); end
        checks++; if (go_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_fetch got=v%0b/b%0b exp=v0/b1", go_valid, busy); end
        checks++; if (rd_addr_0 !== 6'd5 || rd_addr_1 !== 6'd9) begin errors++; $display("FAIL basic_rd_addr got=%0d/%0d exp=5/9", rd_addr_0, rd_addr_1); end
        tick();
        checks++; if (go_valid !== 1'b1) begin errors++; $display("FAIL basic_go_valid got=%0b exp=1", go_valid); end
        checks++; if (go_label_a !== la || go_label_b !== lb) begin errors++; $display("FAIL basic_labels got=%0h/%0h exp=%0h/%0h", go_label_a, go_label_b, la, lb); end
        checks++; if (go_out !== 6'd12 || go_type !== 2'd1) begin errors++; $display("FAIL basic_out got=%0d/%0d exp=12/1", go_out, go_type); end
        checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL basic_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
        tick();
        checks++; if (go_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done got=v%0b/b%0b exp=v0/b0", go_valid, busy); end
        go_ready = 0;
    endtask

    task automatic test_wait;
        logic [K-1:0] la, lb;
        bit ok;
        flush_ram();
        la = rnd_lbl(); lb = rnd_lbl();
        ram_write(5, la);
        send(2'd1, 6'd5, 6'd9, 6'd13, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wait_accept got=0 exp=1"); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (go_valid !== 1'b0) begin errors++; $display("FAIL wait_early_valid c=%0d got=%0b exp=0", c, go_valid); end
            wr_en = (c == 3); wr_addr = 9; wr_data = lb;
            tick();
        end
        wr_en = 0; have[9] = 1; lbl[9] = lb;
        exp_stall += 4;
        checks++; if (go_valid !== 1'b1) begin errors++; $display("FAIL wait_valid got=%0b exp=1", go_valid); end
        checks++; if (go_label_a !== la || go_label_b !== lb) begin errors++; $display("FAIL wait_labels got=%0h/%0h exp=%0h/%0h", go_label_a, go_label_b, la, lb); end
        checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL wait_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
        go_ready = 1; tick(); go_ready = 0;
    endtask

    task automatic test_inv;
        logic [K-1:0] la;
        bit ok;
        flush_ram();
        la = rnd_lbl();
        ram_write(3, la);
        send(2'd2, 6'd3, 6'd7, 6'd20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL inv_accept got=0 exp=1"); end
        tick();
        checks++; if (go_valid !== 1'b1) begin errors++; $display("FAIL inv_valid got=%0b exp=1", go_valid); end
        checks++; if (go_label_a !== la || go_label_b !== '0) begin errors++; $display("FAIL inv_labels got=%0h/%0h exp=%0h/0", go_label_a, go_label_b, la); end
        checks++; if (go_type !== 2'd2 || go_out !== 6'd20) begin errors++; $display("FAIL inv_out got=%0d/%0d exp=2/20", go_type, go_out); end
        checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL inv_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
        go_ready = 1; tick(); go_ready = 0;
    endtask

    task automatic test_back_to_back;
        logic [S-1:0] ga [8], gb [8];
        logic [1:0]   gt [8];
        logic [K-1:0] la;
        int sent, got;
        bit ok;
        flush_ram();
        for (int i = 0; i < 16; i++) ram_write(S'(i), rnd_lbl());
        for (int i = 0; i < 8; i++) begin
            ga[i] = S'(i); gb[i] = S'((i + 3) % 16); gt[i] = 2'(i % 4);
        end
        ga[3] = 7; gb[3] = 7;
        sent = 0; got = 0;
        go_ready = 1;
        for (int c = 0; c <= 16; c++) begin
            if (go_valid) begin
                checks++; if (go_out !== S'(32 + got) || go_type !== gt[got]) begin errors++; $display("FAIL b2b_order got=%0d/%0d exp=%0d/%0d", go_out, go_type, 32 + got, gt[got]); end
                checks++; if (go_label_a !== lbl[ga[got]] || go_label_b !== ((gt[got] == 2'd2) ? '0 : lbl[gb[got]])) begin errors++; $display("FAIL b2b_labels idx=%0d got=%0h/%0h", got, go_label_a, go_label_b); end
                got++;
            end
            gd_valid = (sent < 8);
            if (sent < 8) begin
                gd_type = gt[sent]; gd_in_a = ga[sent]; gd_in_b = gb[sent]; gd_out = S'(32 + sent);
            end
            #1;
            checks++; if (gd_ready !== ((c % 2) == 0)) begin errors++; $display("FAIL b2b_gd_ready c=%0d got=%0b exp=%0b", c, gd_ready, (c % 2) == 0); end
            if (gd_valid && gd_ready) sent++;
            tick();
        end
        gd_valid = 0;
        checks++; if (got !== 8 || sent !== 8) begin errors++; $display("FAIL b2b_count got=%0d issued %0d sent exp=8", got, sent); end
        checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL b2b_stall got=%0d exp=%0d", stall_cnt, exp_stall); end

        go_ready = 0;
        send(2'd0, 6'd1, 6'd2, 6'd50, ok);
        tick();
        la = lbl[1];
        for (int h = 0; h < 3; h++) begin
            #1;
            checks++; if (go_valid !== 1'b1 || go_out !== 6'd50 || go_label_a !== la) begin errors++; $display("FAIL hold_stable h=%0d got=v%0b/%0d exp=v1/50", h, go_valid, go_out); end
            checks++; if (gd_ready !== 1'b0) begin errors++; $display("FAIL hold_gd_ready h=%0d got=%0b exp=0", h, gd_ready); end
            tick();
        end
        go_ready = 1;
        #1;
        checks++; if (gd_ready !== 1'b1) begin errors++; $display("FAIL hold_release got=%0b exp=1", gd_ready); end
        tick();
        go_ready = 0;
        checks++; if (go_valid !== 1'b0) begin errors++; $display("FAIL hold_done got=%0b exp=0", go_valid); end
    endtask

    task automatic test_timeout;
        bit ok;
        flush_ram();
        send(2'd1, 6'd1, 6'd2, 6'd60, ok);
        for (int k = 1; k <= 18; k++) begin
            tick();
            checks++; if (dep_timeout !== (k >= TMAX)) begin errors++; $display("FAIL timeout_dep k=%0d got=%0b exp=%0b", k, dep_timeout, k >= TMAX); end
            checks++; if (go_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid k=%0d got=%0b exp=0", k, go_valid); end
        end
        exp_stall += 18;
        checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL timeout_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
        clr = 1; tick(); clr = 0;
        exp_stall = 0;
        checks++; if (busy !== 1'b0 || gd_ready !== 1'b1) begin errors++; $display("FAIL clr_state got=b%0b/r%0b exp=b0/r1", busy, gd_ready); end
        checks++; if (dep_timeout !== 1'b0 || stall_cnt !== 32'd0) begin errors++; $display("FAIL clr_counters got=%0b/%0d exp=0/0", dep_timeout, stall_cnt); end
        ram_write(1, rnd_lbl());
        ram_write(2, rnd_lbl());
        tick();
        checks++; if (go_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clr_no_issue got=v%0b/b%0b exp=0/0", go_valid, busy); end
    endtask

    task automatic test_async_reset;
        logic [K-1:0] la, lb;
        bit ok;
        flush_ram();
        la = rnd_lbl(); lb = rnd_lbl();
        ram_write(4, la);
        send(2'd1, 6'd4, 6'd5, 6'd33, ok);
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy got=%0b exp=1", busy); end
        #2 rst = 0;
        #1;
        checks++; if (busy !== 1'b0 || go_valid !== 1'b0 || gd_ready !== 1'b1) begin errors++; $display("FAIL arst_state got=b%0b/v%0b/r%0b exp=0/0/1", busy, go_valid, gd_ready); end
        checks++; if (stall_cnt !== 32'd0 || rd_addr_0 !== '0 || go_out !== '0) begin errors++; $display("FAIL arst_regs got=%0d/%0d/%0d exp=0", stall_cnt, rd_addr_0, go_out); end
        tick();
        rst = 1;
        exp_stall = 0; exp_to = 0;
        ram_write(5, lb);
        send(2'd1, 6'd4, 6'd5, 6'd33, ok);
        tick();
        checks++; if (go_valid !== 1'b1 || go_out !== 6'd33) begin errors++; $display("FAIL arst_after got=v%0b/%0d exp=1/33", go_valid, go_out); end
        checks++; if (go_label_a !== la || go_label_b !== lb || stall_cnt !== 32'd0) begin errors++; $display("FAIL arst_after_labels got=%0h/%0h/%0d", go_label_a, go_label_b, stall_cnt); end
        go_ready = 1; tick(); go_ready = 0;
    endtask

    task automatic test_random;
        logic [1:0]   t;
        logic [S-1:0] a, b, o, wa;
        logic [K-1:0] wd;
        int  da, db, st, h;
        bit  ok, cap, ready, wrote;
        flush_ram();
        for (int g = 0; g < 40; g++) begin
            t = 2'($urandom_range(0, 3));
            a = S'($urandom_range(0, N - 1));
            b = S'($urandom_range(0, N - 1));
            o = S'($urandom_range(0, N - 1));
            if (!have[a] && $urandom_range(0, 2) == 0) ram_write(a, rnd_lbl());
            if (!have[b] && $urandom_range(0, 2) == 0) ram_write(b, rnd_lbl());
            da = have[a] ? -1 : int'($urandom_range(0, 20));
            db = (t == 2'd2 || have[b] || b == a) ? -1 : int'($urandom_range(0, 20));
            if (db == da && db >= 0) db = da + 1;
            send(t, a, b, o, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rnd_accept g=%0d", g); end
            st = 0; cap = 0;
            for (int c = 0; c < 60; c++) begin
                checks++; if (go_valid !== cap) begin errors++; $display("FAIL rnd_valid g=%0d c=%0d got=%0b exp=%0b", g, c, go_valid, cap); end
                if (cap) break;
                ready = have[a] && (t == 2'd2 || have[b]);
                if (ready) cap = 1; else st++;
                wrote = 0;
                if (c == da) begin wa = a; wrote = 1; end
                else if (c == db) begin wa = b; wrote = 1; end
                wd = rnd_lbl();
                wr_en = wrote; wr_addr = wa; wr_data = wd;
                tick();
                wr_en = 0;
                if (wrote) begin have[wa] = 1; lbl[wa] = wd; end
            end
            exp_stall += st;
            if (st >= TMAX) exp_to = 1;
            checks++; if (go_label_a !== lbl[a] || go_label_b !== ((t == 2'd2) ? '0 : lbl[b])) begin errors++; $display("FAIL rnd_labels g=%0d got=%0h/%0h exp=%0h/%0h", g, go_label_a, go_label_b, lbl[a], (t == 2'd2) ? '0 : lbl[b]); end
            checks++; if (go_type !== t || go_out !== o) begin errors++; $display("FAIL rnd_out g=%0d got=%0d/%0d exp=%0d/%0d", g, go_type, go_out, t, o); end
            checks++; if (stall_cnt !== 32'(exp_stall) || dep_timeout !== exp_to) begin errors++; $display("FAIL rnd_status g=%0d got=%0d/%0b exp=%0d/%0b", g, stall_cnt, dep_timeout, exp_stall, exp_to); end
            h = int'($urandom_range(0, 2));
            for (int i = 0; i < h; i++) begin
                tick();
                checks++; if (go_valid !== 1'b1 || go_out !== o || gd_ready !== 1'b0) begin errors++; $display("FAIL rnd_hold g=%0d got=v%0b/%0d/r%0b", g, go_valid, go_out, gd_ready); end
            end
            go_ready = 1; tick(); go_ready = 0;
            checks++; if (go_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rnd_done g=%0d got=v%0b/b%0b exp=0/0", g, go_valid, busy); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_inv();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
